bias_act_scheduler: RTL
=======================

// Module: bias_act_scheduler
// PURPOSE
//  Sequences one layer's systolic-array column results through bias add and the bias_activation unit.
//  Accepts accumulator words row-major (col 0..num_cols-1, then next row) and holds a per-column bias table.
//  Rescales/saturates each word, adds its column bias, applies ReLU/sigmoid and buffers results for the next layer.
//  Sits between array drain logic and the activation writeback/next-layer input.
// PARAMETERS
//  DATA_WIDTH  16  signed activation/bias width, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//  ACC_WIDTH   32  signed accumulator width, Q.(2*FRAC_BITS)
//  FRAC_BITS   8   fractional bits of DATA_WIDTH values; acc shifted right by FRAC_BITS
//  MAX_COLS    8   bias table depth / max columns per layer
//  CNT_WIDTH   16  row counter width
// PORTS
//  clk_i           in   1                    clock
//  rst_ni          in   1                    async active-low reset
//  start_i         in   1                    begin layer (sampled in IDLE only)
//  activ_type_i    in   2                    0 ReLU, 1 sigmoid, 2/3 output zero; latched on start
//  num_cols_i      in   $clog2(MAX_COLS+1)   columns per row; latched on start
//  num_rows_i      in   CNT_WIDTH            rows in layer; latched on start
//  bias_wr_en_i    in   1                    bias table write strobe
//  bias_wr_addr_i  in   $clog2(MAX_COLS)     bias column index
//  bias_wr_data_i  in   DATA_WIDTH           signed bias value
//  acc_valid_i     in   1                    accumulator word valid
//  acc_ready_o     out  1                    accumulator word accepted when valid&ready
//  acc_data_i      in   ACC_WIDTH            signed accumulator word
//  y_valid_o       out  1                    result valid
//  y_ready_i       in   1                    consumer ready
//  y_data_o        out  DATA_WIDTH           activated result
//  y_col_o         out  $clog2(MAX_COLS)     column index of y_data_o
//  busy_o          out  1                    state != IDLE
//  done_o          out  1                    1-cycle pulse, last result consumed
//  err_o           out  1                    sticky: start with num_cols 0 or >MAX_COLS, or num_rows 0; cleared by next valid start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, FIFO empty, bias table all 0, err_o 0.
//  FSM IDLE->RUN: start_i & valid config; latch config, clear col/row counters. Invalid config: set err_o, stay IDLE.
//  RUN->DRAIN: accepting word with col==num_cols-1 & row==num_rows-1. DRAIN->IDLE: FIFO empty; done_o pulses that cycle.
//  start_i outside IDLE ignored. Bias writes honoured in IDLE only, ignored (no error) in RUN/DRAIN; write+start same cycle: write lands first, layer uses it.
//  acc_ready_o = (state==RUN) & (fifo_count<2); registered-count based, no comb path from y_ready_i.
//  Per accepted word: z = sat_DATA((acc >>> FRAC_BITS) + sext(bias[col])); arithmetic shift, saturate to [-2^(DW-1), 2^(DW-1)-1].
//  z drives bias_activation (comb); result + col pushed into FIFO in same cycle -> latency 1 clk accept-to-y_valid_o.
//  col increments per accept, wraps to 0 at num_cols-1 and increments row.
//  FIFO: 2 entries, push/pop same cycle when full allowed only via pop-first (count stays 2 not possible since ready=0 at full).
//  y_valid_o = FIFO non-empty; y_data_o/y_col_o stable while y_valid_o & !y_ready_i.
//  Reset mid-layer: immediate abort, FIFO flushed, no done_o.
// STRUCTURE
//  Package ffn_pkg: activ_e {ACT_RELU=0, ACT_SIGMOID=1}, sched_state_e {IDLE,RUN,DRAIN}, function sat_add().
//  Sub-modules: existing bias_activation (DATA_WIDTH); new bias_act_fifo2 (2-entry data+col FIFO, async reset).
//  Top holds FSM, counters, bias table (flops), shift/add/saturate.
// TESTING
//  ReLU, cols=2 rows=1, bias{2,-1}, acc {0x0300,0x0200} -> y {5,1}, cols {0,1}, done_o one pulse.
//  ReLU, bias[0]=2, acc=-0x0500 -> y=0; same with activ_type 2 -> y=0; sigmoid acc 0 bias 0 -> sigmoid(0) code.
//  Saturation: acc=0x7FFF_FF00 bias 0x7FFF -> z=0x7FFF; acc=0x8000_0000 bias 0x8000 -> z=0x8000 (ReLU y=0).
//  Backpressure: y_ready_i=0, stream 3 words -> 2 buffered, acc_ready_o=0, order kept after release.
//  Config errors: start with num_cols 0 / 9 / rows 0 -> err_o=1, busy_o=0; valid start clears err_o.
//  Reset asserted mid-RUN: outputs 0 same edge; re-start completes normally, bias table reads 0.

Source files
------------

// File: rtl/ffn_pkg.sv
// Shared types and helpers for the feed-forward bias/activation datapath.
package ffn_pkg;

  typedef enum logic [1:0] {
    ACT_RELU    = 2'd0,
    ACT_SIGMOID = 2'd1
  } activ_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_e;

  localparam int unsigned SatW = 64;

  // Signed add clamped to a two's-complement range of the given width.
  function automatic logic signed [SatW-1:0] sat_add(input logic signed [SatW-1:0] a,
                                                     input logic signed [SatW-1:0] b,
                                                     input int unsigned            width);
    logic signed [SatW-1:0] sum;
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/bias_act_fifo2.sv
// Two-entry FIFO carrying an activated result and its column index; slot 0 is the head.
module bias_act_fifo2 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COL_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [COL_WIDTH-1:0]  push_col_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [COL_WIDTH-1:0]  col_o
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [COL_WIDTH-1:0]  col_q  [2];
  logic [COL_WIDTH-1:0]  col_d  [2];
  logic [1:0]            count_q, count_d;
  logic                  pop_ok, push_ok;
  logic [1:0]            wr_idx;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  // Pop frees a slot first, so a push is legal against a full FIFO only alongside a pop.
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);
  assign wr_idx  = count_q - {1'b0, pop_ok};

  always_comb begin
    data_d  = data_q;
    col_d   = col_q;
    count_d = count_q - {1'b0, pop_ok} + {1'b0, push_ok};
    if (pop_ok) begin
      data_d[0] = data_q[1];
      col_d[0]  = col_q[1];
    end
    if (push_ok) begin
      if (wr_idx == 2'd0) begin
        data_d[0] = push_data_i;
        col_d[0]  = push_col_i;
      end else begin
        data_d[1] = push_data_i;
        col_d[1]  = push_col_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      col_q[0]  <= '0;
      col_q[1]  <= '0;
      count_q   <= '0;
    end else begin
      data_q  <= data_d;
      col_q   <= col_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign data_o  = data_q[0];
  assign col_o   = col_q[0];

endmodule

// File: rtl/bias_activation.sv
// Combinational activation: ReLU, hard sigmoid (x/4 + 0.5 clamped to [0,1]) or zero.
module bias_activation import ffn_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0] z_i,
  input  logic [1:0]            activ_type_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  localparam logic signed [DATA_WIDTH-1:0] One  = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0] Half = DATA_WIDTH'(1) << (FRAC_BITS - 1);

  logic signed [DATA_WIDTH-1:0] z;
  logic signed [DATA_WIDTH-1:0] sig;

  assign z   = $signed(z_i);
  assign sig = (z >>> 2) + Half;

  always_comb begin
    y_o = '0;
    if (activ_type_i == ACT_RELU) begin
      y_o = z[DATA_WIDTH-1] ? '0 : z_i;
    end else if (activ_type_i == ACT_SIGMOID) begin
      if (sig[DATA_WIDTH-1]) y_o = '0;
      else if (sig > One)    y_o = One;
      else                   y_o = sig;
    end
  end

endmodule

// File: rtl/bias_act_scheduler.sv
// Sequences a layer's accumulator words through rescale, bias add, saturation and activation.
module bias_act_scheduler import ffn_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned MAX_COLS   = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [1:0]                    activ_type_i,
  input  logic [$clog2(MAX_COLS+1)-1:0] num_cols_i,
  input  logic [CNT_WIDTH-1:0]          num_rows_i,
  input  logic                          bias_wr_en_i,
  input  logic [$clog2(MAX_COLS)-1:0]   bias_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         bias_wr_data_i,
  input  logic                          acc_valid_i,
  output logic                          acc_ready_o,
  input  logic [ACC_WIDTH-1:0]          acc_data_i,
  output logic                          y_valid_o,
  input  logic                          y_ready_i,
  output logic [DATA_WIDTH-1:0]         y_data_o,
  output logic [$clog2(MAX_COLS)-1:0]   y_col_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned ColW = $clog2(MAX_COLS);
  localparam int unsigned NcW  = $clog2(MAX_COLS + 1);

  sched_state_e          state_q, state_d;
  logic [1:0]            activ_q, activ_d;
  logic [NcW-1:0]        ncols_q, ncols_d;
  logic [CNT_WIDTH-1:0]  nrows_q, nrows_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] bias_q [MAX_COLS];

  logic                        cfg_ok, acc_fire, last_col, last_row;
  logic signed [ACC_WIDTH-1:0] acc_shift;
  logic [DATA_WIDTH-1:0]       bias_cur, z, act_y;
  logic [1:0]                  fifo_count;

  assign cfg_ok    = (num_cols_i != '0) && (32'(num_cols_i) <= MAX_COLS) && (num_rows_i != '0);
  assign acc_ready_o = (state_q == RUN) && (fifo_count < 2'd2);
  assign acc_fire  = acc_valid_i && acc_ready_o;
  assign last_col  = (NcW'(col_q) == ncols_q - NcW'(1));
  assign last_row  = (row_q == nrows_q - CNT_WIDTH'(1));

  assign acc_shift = $signed(acc_data_i) >>> FRAC_BITS;
  assign bias_cur  = bias_q[col_q];
  assign z = DATA_WIDTH'(sat_add({{(SatW-ACC_WIDTH){acc_shift[ACC_WIDTH-1]}}, acc_shift},
                                 {{(SatW-DATA_WIDTH){bias_cur[DATA_WIDTH-1]}}, bias_cur},
                                 DATA_WIDTH));

  always_comb begin
    state_d = state_q;
    activ_d = activ_q;
    ncols_d = ncols_q;
    nrows_d = nrows_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            state_d = RUN;
            activ_d = activ_type_i;
            ncols_d = num_cols_i;
            nrows_d = num_rows_i;
            col_d   = '0;
            row_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (acc_fire) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + CNT_WIDTH'(1);
            if (last_row) state_d = DRAIN;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      DRAIN: begin
        if (fifo_count == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      activ_q <= '0;
      ncols_q <= '0;
      nrows_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      activ_q <= activ_d;
      ncols_q <= ncols_d;
      nrows_q <= nrows_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // Table writes only land while idle so a running layer sees a stable bias set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAX_COLS); i++) bias_q[i] <= '0;
    end else if ((state_q == IDLE) && bias_wr_en_i) begin
      bias_q[bias_wr_addr_i] <= bias_wr_data_i;
    end
  end

  bias_activation #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_act (
    .z_i          (z),
    .activ_type_i (activ_q),
    .y_o          (act_y)
  );

  bias_act_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .COL_WIDTH  (ColW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (acc_fire),
    .push_data_i (act_y),
    .push_col_i  (col_q),
    .pop_i       (y_valid_o && y_ready_i),
    .count_o     (fifo_count),
    .valid_o     (y_valid_o),
    .data_o      (y_data_o),
    .col_o       (y_col_o)
  );

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DRAIN) && (fifo_count == 2'd0);
  assign err_o  = err_q;

endmodule
